// File: rtl/add_seq_arbiter_if.sv
// Request, response and shared-adder signals of the two-requester sequential adder.
// The slave modport is the arbiter; the master modport is its environment.
interface add_seq_arbiter_if;

  // requester 0
  logic        req0_valid;
  logic [13:0] req0_a;
  logic [13:0] req0_b;
  logic        req0_ready;

  // requester 1
  logic        req1_valid;
  logic [13:0] req1_a;
  logic [13:0] req1_b;
  logic        req1_ready;

  // result
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [13:0] rsp_sum;
  logic        rsp_cout;

  // external 7-bit adder, combinational, no carry-in
  logic [6:0]  add_a;
  logic [6:0]  add_b;
  logic [6:0]  add_s;
  logic        add_cout;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout,
    input  rsp_ready,
    output add_a, add_b,
    input  add_s, add_cout
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
    output rsp_ready,
    input  add_a, add_b,
    output add_s, add_cout
  );

endinterface

// File: rtl/add_seq_arbiter.sv
// Round-robin arbiter in front of a 14-bit adder built from one shared external 7-bit adder.
// A transaction runs a low pass, a high pass and, when the low half carried, an increment pass
// on the high half, then holds the result until the consumer takes it.
module add_seq_arbiter (
  input  logic               clk,
  input  logic               rst,
  add_seq_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLo,
    StHi,
    StInc,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] a_q, a_d;
  logic [13:0] b_q, b_d;
  logic [13:0] sum_q, sum_d;
  logic        id_q, id_d;
  logic        carry_q, carry_d;   // carry out of the low pass
  logic        cout_q, cout_d;     // carry out of bit 13
  logic        last_q, last_d;     // requester granted at the most recent acceptance

  logic        grant_valid;
  logic        grant_id;
  logic        accept;

  // Grant selection: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    grant_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_q;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Ready only towards the granted requester, only while idle and out of reset.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    if (!rst && (state_q == StIdle) && grant_valid) begin
      bus.req0_ready = ~grant_id;
      bus.req1_ready = grant_id;
    end
  end

  assign accept = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);

  // Shared adder operand steering; parked at zero when no pass is running.
  always_comb begin
    bus.add_a = 7'd0;
    bus.add_b = 7'd0;
    if (!rst) begin
      unique case (state_q)
        StLo: begin
          bus.add_a = a_q[6:0];
          bus.add_b = b_q[6:0];
        end
        StHi: begin
          bus.add_a = a_q[13:7];
          bus.add_b = b_q[13:7];
        end
        StInc: begin
          bus.add_a = sum_q[13:7];
          bus.add_b = 7'd1;
        end
        default: begin
          bus.add_a = 7'd0;
          bus.add_b = 7'd0;
        end
      endcase
    end
  end

  // Next-state and datapath capture for each pass.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    id_d    = id_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = grant_id ? bus.req1_a : bus.req0_a;
          b_d     = grant_id ? bus.req1_b : bus.req0_b;
          id_d    = grant_id;
          last_d  = grant_id;
          state_d = StLo;
        end
      end
      StLo: begin
        sum_d[6:0] = bus.add_s;
        carry_d    = bus.add_cout;
        state_d    = StHi;
      end
      StHi: begin
        sum_d[13:7] = bus.add_s;
        cout_d      = bus.add_cout;
        state_d     = carry_q ? StInc : StDone;
      end
      StInc: begin
        // Only one of the high-pass and increment carries can ever be set.
        sum_d[13:7] = bus.add_s;
        cout_d      = cout_q | bus.add_cout;
        state_d     = StDone;
      end
      StDone: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset; the reset pointer lets requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= 14'd0;
      b_q     <= 14'd0;
      sum_q   <= 14'd0;
      id_q    <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      last_q  <= last_d;
    end
  end

  assign bus.rsp_valid = (state_q == StDone);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;

  // Structural invariants of the handshake.
  a_one_ready : assert property (@(posedge clk) disable iff (rst)
    !(bus.req0_ready && bus.req1_ready));

  a_ready_idle : assert property (@(posedge clk) disable iff (rst)
    (bus.req0_ready || bus.req1_ready) |-> (state_q == StIdle));

  a_rsp_hold : assert property (@(posedge clk) disable iff (rst)
    (bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable(bus.rsp_sum) && $stable(bus.rsp_id) && $stable(bus.rsp_cout)));

endmodule

// File: tb/tb_add_seq_arbiter.sv
// Bench for add_seq_arbiter: directed corner cases, then randomized traffic, all checked by a
// scoreboard fed at each acceptance and drained by a monitor at each response.
module tb_add_seq_arbiter;

  logic clk;
  logic rst;

  add_seq_arbiter_if bus();

  add_seq_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External 7-bit adder without carry-in.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  typedef struct {
    bit        id;
    bit [13:0] sum;
    bit        cout;
    int        acc_cyc;
    int        lat;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  bit   last_model;
  bit   rsp_seen;
  bit   mon_g;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Expected result straight from integer addition; the extra pass exists iff the low halves carry.
  function automatic exp_t model(input bit id, input bit [13:0] a, input bit [13:0] b,
                                 input int c);
    exp_t        e;
    int unsigned total;
    total     = 32'(a) + 32'(b);
    e.id      = id;
    e.sum     = 14'(total % 16384);
    e.cout    = (total >= 16384);
    e.lat     = ((32'(a) % 128) + (32'(b) % 128) >= 128) ? 4 : 3;
    e.acc_cyc = c;
    return e;
  endfunction

  function automatic bit [13:0] rnd_operand();
    bit [13:0] r;
    r = 14'($urandom);
    if ($urandom_range(0, 3) == 0) r[6:0] = 7'h7f;
    if ($urandom_range(0, 5) == 0) r[13:7] = 7'h7f;
    return r;
  endfunction

  // Monitor: grant/acceptance model and response scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      check("add_a_in_reset", 32'(bus.add_a), 32'd0);
      check("add_b_in_reset", 32'(bus.add_b), 32'd0);
      sb.delete();
      last_model = 1'b1;
      rsp_seen   = 1'b0;
    end else begin
      if (sb.size() == 0 && (bus.req0_valid || bus.req1_valid)) begin
        if (bus.req0_valid && bus.req1_valid) mon_g = ~last_model;
        else mon_g = bus.req1_valid;
        check("grant_ready0", 32'(bus.req0_ready), 32'(mon_g == 1'b0));
        check("grant_ready1", 32'(bus.req1_ready), 32'(mon_g == 1'b1));
        last_model = mon_g;
        if (mon_g) sb.push_back(model(1'b1, bus.req1_a, bus.req1_b, cyc));
        else sb.push_back(model(1'b0, bus.req0_a, bus.req0_b, cyc));
      end else begin
        check("busy_ready0", 32'(bus.req0_ready), 32'd0);
        check("busy_ready1", 32'(bus.req1_ready), 32'd0);
      end

      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end else begin
          check("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
          check("rsp_sum", 32'(bus.rsp_sum), 32'(sb[0].sum));
          check("rsp_cout", 32'(bus.rsp_cout), 32'(sb[0].cout));
          check("add_idle_in_done", 32'({bus.add_a, bus.add_b}), 32'd0);
          if (!rsp_seen) begin
            check("rsp_latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
            rsp_seen = 1'b1;
          end
          if (bus.rsp_ready) begin
            void'(sb.pop_front());
            rsp_seen = 1'b0;
          end
        end
      end else if (sb.size() > 0 && (cyc - sb[0].acc_cyc) > 40) begin
        check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
        void'(sb.pop_front());
        rsp_seen = 1'b0;
      end
    end
  end

  task automatic send(input bit id, input bit [13:0] a, input bit [13:0] b);
    bit done;
    done = 1'b0;
    if (id) begin
      bus.req1_valid = 1'b1;
      bus.req1_a     = a;
      bus.req1_b     = b;
    end else begin
      bus.req0_valid = 1'b1;
      bus.req0_a     = a;
      bus.req0_b     = b;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = id ? bus.req1_ready : bus.req0_ready;
    end
    check("accept_seen", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    if (id) bus.req1_valid = 1'b0;
    else bus.req0_valid = 1'b0;
  endtask

  task automatic expect_rsp(input bit id, input bit [13:0] sum, input bit cout);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.rsp_valid;
    end
    check("dir_rsp_seen", 32'(got), 32'd1);
    if (got) begin
      check("dir_rsp_id", 32'(bus.rsp_id), 32'(id));
      check("dir_rsp_sum", 32'(bus.rsp_sum), 32'(sum));
      check("dir_rsp_cout", 32'(bus.rsp_cout), 32'(cout));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  bit acc0;
  bit acc1;
  bit drained;

  initial begin
    checks         = 0;
    errors         = 0;
    cyc            = 0;
    last_model     = 1'b1;
    rsp_seen       = 1'b0;
    rst            = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_a     = 14'd0;
    bus.req0_b     = 14'd0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = 14'd0;
    bus.req1_b     = 14'd0;
    bus.rsp_ready  = 1'b1;
    do_reset();

    @(negedge clk);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("reset_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    check("reset_rsp_cout", 32'(bus.rsp_cout), 32'd0);
    @(posedge clk);
    #1;

    // Basic, increment-pass and both carry-out paths.
    send(1'b0, 14'h0005, 14'h0003);
    expect_rsp(1'b0, 14'h0008, 1'b0);
    send(1'b1, 14'h007f, 14'h0001);
    expect_rsp(1'b1, 14'h0080, 1'b0);
    send(1'b0, 14'h3fff, 14'h0001);
    expect_rsp(1'b0, 14'h0000, 1'b1);
    send(1'b0, 14'h2000, 14'h2000);
    expect_rsp(1'b0, 14'h0000, 1'b1);

    // Both requesters valid continuously from reset: grants alternate starting with 0.
    do_reset();
    bus.req0_a     = 14'h1234;
    bus.req0_b     = 14'h0111;
    bus.req1_a     = 14'h0f0f;
    bus.req1_b     = 14'h00f1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bit kid;
      kid = k[0];
      expect_rsp(kid, kid ? 14'h1000 : 14'h1345, 1'b0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Consumer stalls in DONE: result held, no acceptance, then release.
    bus.rsp_ready = 1'b0;
    send(1'b0, 14'h0100, 14'h0200);
    expect_rsp(1'b0, 14'h0300, 1'b0);
    bus.req0_valid = 1'b1;
    bus.req0_a     = 14'h0001;
    bus.req0_b     = 14'h0002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_rsp_sum", 32'(bus.rsp_sum), 32'h0300);
      check("stall_ready0", 32'(bus.req0_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_done_ready0", 32'(bus.req0_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    expect_rsp(1'b0, 14'h0003, 1'b0);

    // Reset in the high pass abandons the transaction; the next one completes.
    send(1'b1, 14'h0011, 14'h0022);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abandoned_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(1'b0, 14'h1fff, 14'h0001);
    expect_rsp(1'b0, 14'h2000, 1'b0);

    // Randomized traffic with valid drops and consumer backpressure.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (!bus.req0_valid || acc0) begin
        bus.req0_valid = 1'($urandom_range(0, 1));
        bus.req0_a     = rnd_operand();
        bus.req0_b     = rnd_operand();
      end else if ($urandom_range(0, 7) == 0) begin
        bus.req0_valid = 1'b0;
      end
      if (!bus.req1_valid || acc1) begin
        bus.req1_valid = 1'($urandom_range(0, 1));
        bus.req1_a     = rnd_operand();
        bus.req1_b     = rnd_operand();
      end else if ($urandom_range(0, 7) == 0) begin
        bus.req1_valid = 1'b0;
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end

    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    drained        = 1'b0;
    for (int i = 0; i < 60 && !drained; i++) begin
      @(negedge clk);
      drained = (sb.size() == 0);
    end
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_seq_arbiter.md
ADD_SEQ_ARBITER -- requirements
Module: add_seq_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: 14-bit operands, one shared 7-bit adder.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an operand pair.
REQ-006 req0_a, req0_b  input  14 each  requester 0 operands.
REQ-007 req0_ready  output  1  requester 0 operands accepted this cycle when high with req0_valid.
REQ-008 req1_valid, req1_a, req1_b, req1_ready SHALL mirror REQ-005 to REQ-007 for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_id  output  1  requester that owns the result.
REQ-012 rsp_sum  output  14  A+B modulo 2^14.
REQ-013 rsp_cout  output  1  carry out of bit 13.
REQ-014 add_a, add_b  output  7 each  operands to the external shared 7-bit adder.
REQ-015 add_s  input  7  adder sum, combinational from add_a/add_b.
REQ-016 add_cout  input  1  adder carry out; the adder has no carry-in.

Function
REQ-017 States: IDLE, LO, HI, INC, DONE; one transaction in flight at most.
REQ-018 IDLE: reqN_ready = granted requester only; acceptance = valid && ready; operands and id are latched on the accepting edge; next state LO.
REQ-019 Arbitration: if one requester is valid, grant it; if both, grant the one not granted last (round-robin); the last-granted pointer updates only on acceptance.
REQ-020 Both ready outputs SHALL be 0 in all states other than IDLE.
REQ-021 LO: add_a/add_b = latched operand bits [6:0]; capture add_s into sum[6:0] and add_cout into the internal carry; next state HI.
REQ-022 HI: add_a/add_b = operand bits [13:7]; capture add_s into sum[13:7] and add_cout into rsp_cout; next state INC if the LO carry is 1, else DONE.
REQ-023 INC: add_a = sum[13:7], add_b = 7'd1; capture add_s into sum[13:7]; rsp_cout = HI carry OR add_cout; next state DONE.
REQ-024 add_a/add_b SHALL be 0 in IDLE and DONE.
REQ-025 DONE: rsp_valid = 1; rsp_id/rsp_sum/rsp_cout held stable until rsp_valid && rsp_ready, then next state IDLE; no new acceptance in the same cycle.
REQ-026 Latency: acceptance edge at cycle T; rsp_valid first high at T+3 with no low carry, T+4 with a low carry.
REQ-027 A requester that deasserts valid before acceptance SHALL lose nothing; the grant is re-evaluated every IDLE cycle.

Reset
REQ-028 On rst = 1 at a clock edge: state IDLE, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_cout 0, internal carry 0, pointer set so requester 0 wins the first tie.
REQ-029 Reset during LO/HI/INC/DONE SHALL abandon the transaction with no response; ready may assert the cycle after reset releases.
REQ-030 add_a/add_b SHALL be 0 while rst is high.

Verification
REQ-031 req0 0x0005+0x0003, rsp_ready=1 -> rsp_sum 0x0008, rsp_cout 0, rsp_id 0, rsp_valid at T+3.
REQ-032 req1 0x007F+0x0001 -> INC pass taken, rsp_sum 0x0080, rsp_cout 0, rsp_id 1, rsp_valid at T+4.
REQ-033 req0 0x3FFF+0x0001 -> rsp_sum 0x0000, rsp_cout 1 from the INC pass; and 0x2000+0x2000 -> rsp_sum 0x0000, rsp_cout 1 from the HI pass, T+3.
REQ-034 Both valid continuously after reset -> grants alternate 0,1,0,1; each result tagged with the correct rsp_id.
REQ-035 rsp_ready held low 5 cycles in DONE -> outputs stable, both ready 0; rsp_ready=1 -> IDLE the next cycle.
REQ-036 rst pulsed during HI -> no rsp_valid; a new request is then accepted and completes correctly.
